// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU: operand width, opcode encodings and
// the packed condition-flag record used by the execution stage.
package alu4_pkg;

   localparam int WIDTH = 4;

   localparam logic [2:0] OP_NOTA = 3'b000;
   localparam logic [2:0] OP_NOTB = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_ADD  = 3'b110;
   localparam logic [2:0] OP_SUB  = 3'b111;

   typedef struct packed {
      logic c;
      logic n;
      logic z;
      logic v;
   } alu4_flags_t;

endpackage

// File: rtl/alu4_addsub.sv
// 4-bit carry-lookahead adder/subtractor shared by ADD and SUB.
// Subtraction is a + ~b + 1: operand B is inverted and the carry-in is 1.
module alu4_addsub
   import alu4_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   cy;

   assign b_x  = b ^ {WIDTH{sub}};
   assign gen  = a & b_x;
   assign prop = a ^ b_x;

   // Every carry is formed directly from generate/propagate terms and the
   // carry-in, so no carry ripples through the lower bit positions.
   assign cy[0] = sub;
   assign cy[1] = gen[0] | (prop[0] & cy[0]);
   assign cy[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cy[0]);
   assign cy[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                | (prop[2] & prop[1] & prop[0] & cy[0]);
   assign cy[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                | (prop[3] & prop[2] & prop[1] & gen[0])
                | (prop[3] & prop[2] & prop[1] & prop[0] & cy[0]);

   assign sum  = prop ^ cy[WIDTH-1:0];
   assign cout = cy[WIDTH];
   // Two's-complement overflow: carry into the sign bit differs from carry out.
   assign ovf  = cy[WIDTH] ^ cy[WIDTH-1];

endmodule

// File: rtl/alu_4bit.sv
// 4-bit ALU execution stage: eight logic/arithmetic ops with NZCV flags.
// Default build registers result and flags (1-cycle latency, async reset).
// Define ALU4_BYPASS_EN to remove the output registers; outputs then follow
// a, b and op combinationally and clk/reset are left unused.
module alu_4bit
   import alu4_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             n,
   output logic             z,
   output logic             v
);

   logic [WIDTH-1:0] sum_p0;
   logic             cout_p0;
   logic             ovf_p0;
   logic             is_sub_p0;
   logic [WIDTH-1:0] res_p0;
   alu4_flags_t      flags_p0;

   assign is_sub_p0 = (op == OP_SUB);

   alu4_addsub u_addsub (
      .a    (a),
      .b    (b),
      .sub  (is_sub_p0),
      .sum  (sum_p0),
      .cout (cout_p0),
      .ovf  (ovf_p0)
   );

   // Stage p0: operation mux and flag derivation; C and V only for ADD/SUB.
   always_comb begin
      res_p0   = '0;
      flags_p0 = '0;
      unique case (op)
         OP_NOTA: res_p0 = ~a;
         OP_NOTB: res_p0 = ~b;
         OP_AND:  res_p0 = a & b;
         OP_OR:   res_p0 = a | b;
         OP_XOR:  res_p0 = a ^ b;
         OP_XNOR: res_p0 = ~(a ^ b);
         OP_ADD,
         OP_SUB: begin
            res_p0     = sum_p0;
            flags_p0.c = cout_p0;
            flags_p0.v = ovf_p0;
         end
         default: res_p0 = '0;
      endcase
      flags_p0.n = res_p0[WIDTH-1];
      flags_p0.z = (res_p0 == '0);
   end

`ifdef ALU4_BYPASS_EN
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ reset;

   assign result = res_p0;
   assign c      = flags_p0.c;
   assign n      = flags_p0.n;
   assign z      = flags_p0.z;
   assign v      = flags_p0.v;
`else
   logic [WIDTH-1:0] res_p1;
   alu4_flags_t      flags_p1;

   // Stage p1: capture result and flags; reset clears everything, Z included.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_p1   <= '0;
         flags_p1 <= '0;
      end else begin
         res_p1   <= res_p0;
         flags_p1 <= flags_p0;
      end
   end

   assign result = res_p1;
   assign c      = flags_p1.c;
   assign n      = flags_p1.n;
   assign z      = flags_p1.z;
   assign v      = flags_p1.v;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit (default registered build).
// Stimulus pushes expected responses into a queue; a monitor pops and
// compares one posedge later against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_4bit;

   logic       clk;
   logic       reset;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] op;
   logic [3:0] result;
   logic       c, n, z, v;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;   // {result, c, n, z, v}
   } item_t;

   item_t exp_q[$];

   alu_4bit dut (
      .clk    (clk),
      .reset  (reset),
      .a      (a),
      .b      (b),
      .op     (op),
      .result (result),
      .c      (c),
      .n      (n),
      .z      (z),
      .v      (v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int to_signed4(input logic [3:0] x);
      return x[3] ? int'(x) - 16 : int'(x);
   endfunction

   // Reference model: integer arithmetic straight from the operation rules.
   function automatic logic [7:0] model(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
      int  ux, uy, s, sx, sy, ss;
      logic [3:0] r;
      logic cf, vf;
      ux = int'(x);
      uy = int'(y);
      sx = to_signed4(x);
      sy = to_signed4(y);
      cf = 1'b0;
      vf = 1'b0;
      case (o)
         3'd0: r = 4'(15 - ux);
         3'd1: r = 4'(15 - uy);
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: r = ~(x ^ y);
         3'd6: begin
            s  = ux + uy;
            r  = 4'(s % 16);
            cf = (s > 15);
            ss = sx + sy;
            vf = (ss > 7) || (ss < -8);
         end
         default: begin
            s  = ux - uy + 16;
            r  = 4'(s % 16);
            cf = (ux >= uy);
            ss = sx - sy;
            vf = (ss > 7) || (ss < -8);
         end
      endcase
      return {r, cf, r[3], (r == 4'd0), vf};
   endfunction

   task automatic drive(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
      item_t it;
      @(negedge clk);
      op = o;
      a  = x;
      b  = y;
      it.op  = o;
      it.a   = x;
      it.b   = y;
      it.exp = model(o, x, y);
      exp_q.push_back(it);
   endtask

   task automatic chk_zero(input string name);
      checks++;
      if ({result, c, n, z, v} !== 8'h00) begin
         errors++;
         $display("FAIL %s: got result=%b c=%b n=%b z=%b v=%b, expected all 0",
                  name, result, c, n, z, v);
      end
   endtask

   // Monitor: one posedge after each issued stimulus the registered output appears.
   initial begin
      item_t it;
      logic [7:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && exp_q.size() > 0) begin
            it  = exp_q.pop_front();
            got = {result, c, n, z, v};
            checks++;
            if (got !== it.exp) begin
               errors++;
               $display("FAIL op%0d a=%b b=%b: got {res,c,n,z,v}=%b_%b expected %b_%b",
                        it.op, it.a, it.b, got[7:4], got[3:0], it.exp[7:4], it.exp[3:0]);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      a     = 4'd0;
      b     = 4'd0;
      op    = 3'd0;
      #1;
      chk_zero("reset_initial");
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset_held");
      @(negedge clk);
      reset = 1'b0;

      // Directed cases from the operation table.
      drive(3'd6, 4'b0111, 4'b0001);
      drive(3'd6, 4'b1111, 4'b0001);
      drive(3'd7, 4'b0011, 4'b0011);
      drive(3'd7, 4'b1000, 4'b0001);
      drive(3'd7, 4'b0001, 4'b0010);
      drive(3'd2, 4'b1100, 4'b1010);
      drive(3'd5, 4'b1100, 4'b1010);
      drive(3'd0, 4'b1111, 4'b0000);
      drive(3'd1, 4'b0000, 4'b0101);
      drive(3'd3, 4'b1100, 4'b1010);
      drive(3'd4, 4'b1100, 4'b1010);

      // Mid-operation reset while output holds 1000.
      drive(3'd2, 4'b1100, 4'b1010);
      @(posedge clk);
      #3;
      checks++;
      if (result !== 4'b1000) begin
         errors++;
         $display("FAIL pre_reset_hold: got result=%b expected 1000", result);
      end
      reset = 1'b1;
      #1;
      chk_zero("reset_async");
      op = 3'd6;
      a  = 4'b0111;
      b  = 4'b0001;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk_zero("reset_through_edge");
      end
      @(negedge clk);
      reset = 1'b0;
      begin
         item_t it;
         it.op  = op;
         it.a   = a;
         it.b   = b;
         it.exp = model(op, a, b);
         exp_q.push_back(it);
      end

      // Randomized traffic, all opcodes and operand values.
      for (int i = 0; i < 300; i++) begin
         drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
